// File: rtl/ethernet_pkg.sv
// Shared constants, state encoding and output beat type for the Ethernet frame parser.
package ethernet_pkg;

    localparam logic [7:0]  PREAMBLE      = 8'h55;
    localparam logic [7:0]  SFD           = 8'hD5;
    localparam logic [15:0] ETH_IPV4      = 16'h0800;
    localparam logic [15:0] ETH_ARP       = 16'h0806;
    localparam logic [47:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;
    localparam logic [15:0] ARP_LEN       = 16'd28;
    localparam logic [15:0] IPV4_MIN_LEN  = 16'd20;

    typedef enum logic [1:0] {
        HUNT,
        HEADER,
        PAYLOAD
    } parse_state_e;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eof;
        logic       err;
    } beat_t;

endpackage

// File: rtl/ethernet_frame_parser_if.sv
// FIFO-side and protocol-side signals of the frame parser, grouped with parser/environment views.
interface ethernet_frame_parser_if;

    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        fifo_rd;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sof;
    logic        out_eof;
    logic        out_err;
    logic [47:0] src_mac;
    logic [15:0] frame_type;
    logic        frame_dropped;

    modport master (
        input  fifo_empty, fifo_data, out_ready,
        output fifo_rd, out_data, out_valid, out_sof, out_eof, out_err,
               src_mac, frame_type, frame_dropped
    );

    modport slave (
        output fifo_empty, fifo_data, out_ready,
        input  fifo_rd, out_data, out_valid, out_sof, out_eof, out_err,
               src_mac, frame_type, frame_dropped
    );

endinterface

// File: rtl/ethernet_out_reg.sv
// One-entry output register holding a payload beat until the consumer accepts it.
module ethernet_out_reg
    import ethernet_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  load,
    input  beat_t beat_in,
    input  logic  ready,
    output logic  valid,
    output beat_t beat_out,
    output logic  slot_free
);

    logic  valid_q;
    beat_t beat_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            beat_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            beat_q  <= beat_in;
        end else if (valid_q && ready) begin
            // Data is kept after acceptance; only the qualifiers drop.
            valid_q     <= 1'b0;
            beat_q.sof  <= 1'b0;
            beat_q.eof  <= 1'b0;
            beat_q.err  <= 1'b0;
        end
    end

    assign valid     = valid_q;
    assign beat_out  = beat_q;
    assign slot_free = !valid_q || ready;

endmodule

// File: rtl/ethernet_frame_parser.sv
// Hunts preamble/SFD, parses the MAC header, filters on destination and streams the payload.
module ethernet_frame_parser
    import ethernet_pkg::*;
#(
    parameter logic [47:0] MY_MAC  = 48'h02_00_00_00_00_01,
    parameter int unsigned PRE_MIN = 2,
    parameter int unsigned MAX_LEN = 1500
) (
    input logic                     clk,
    input logic                     reset,
    input logic                     enable,
    ethernet_frame_parser_if.master bus
);

    localparam logic [15:0] MaxLen = 16'(MAX_LEN);
    localparam logic [2:0]  PreMin = 3'(PRE_MIN);

    parse_state_e state_q, state_d;
    logic [2:0]  pre_cnt_q, pre_cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic [39:0] dest_q, dest_d;
    logic [47:0] hdr_src_q, hdr_src_d;
    logic [7:0]  type_hi_q, type_hi_d;
    logic [47:0] src_mac_q, src_mac_d;
    logic [15:0] frame_type_q, frame_type_d;
    logic [15:0] len_q, len_d;
    logic        len_known_q, len_known_d;
    logic        ipv4_q, ipv4_d;
    logic [7:0]  ip_hi_q, ip_hi_d;
    logic [10:0] pcnt_q, pcnt_d;
    logic        drop_q, drop_d;

    logic        slot_free;
    logic        pop;
    logic        load;
    logic        out_valid;
    beat_t       beat;
    beat_t       out_beat;
    logic [47:0] dest_full;
    logic [15:0] hdr_type;
    logic [15:0] ip_total;

    assign pop       = enable && !bus.fifo_empty && slot_free;
    assign dest_full = {dest_q, bus.fifo_data};
    assign hdr_type  = {type_hi_q, bus.fifo_data};
    assign ip_total  = {ip_hi_q, bus.fifo_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= HUNT;
            pre_cnt_q    <= '0;
            idx_q        <= '0;
            dest_q       <= '0;
            hdr_src_q    <= '0;
            type_hi_q    <= '0;
            src_mac_q    <= '0;
            frame_type_q <= '0;
            len_q        <= '0;
            len_known_q  <= 1'b0;
            ipv4_q       <= 1'b0;
            ip_hi_q      <= '0;
            pcnt_q       <= '0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_cnt_q    <= pre_cnt_d;
            idx_q        <= idx_d;
            dest_q       <= dest_d;
            hdr_src_q    <= hdr_src_d;
            type_hi_q    <= type_hi_d;
            src_mac_q    <= src_mac_d;
            frame_type_q <= frame_type_d;
            len_q        <= len_d;
            len_known_q  <= len_known_d;
            ipv4_q       <= ipv4_d;
            ip_hi_q      <= ip_hi_d;
            pcnt_q       <= pcnt_d;
            drop_q       <= drop_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pre_cnt_d    = pre_cnt_q;
        idx_d        = idx_q;
        dest_d       = dest_q;
        hdr_src_d    = hdr_src_q;
        type_hi_d    = type_hi_q;
        src_mac_d    = src_mac_q;
        frame_type_d = frame_type_q;
        len_d        = len_q;
        len_known_d  = len_known_q;
        ipv4_d       = ipv4_q;
        ip_hi_d      = ip_hi_q;
        pcnt_d       = pcnt_q;
        drop_d       = 1'b0;
        load         = 1'b0;
        beat         = '0;

        if (pop) begin
            unique case (state_q)
                HUNT: begin
                    if (bus.fifo_data == PREAMBLE) begin
                        if (pre_cnt_q != 3'd7) pre_cnt_d = pre_cnt_q + 3'd1;
                    end else if (bus.fifo_data == SFD && pre_cnt_q >= PreMin) begin
                        state_d   = HEADER;
                        idx_d     = '0;
                        pre_cnt_d = '0;
                    end else begin
                        pre_cnt_d = '0;
                    end
                end
                HEADER: begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q <= 4'd5) begin
                        dest_d = dest_full[39:0];
                        if (idx_q == 4'd5 && dest_full != MY_MAC && dest_full != BROADCAST_MAC) begin
                            drop_d  = 1'b1;
                            state_d = HUNT;
                        end
                    end else if (idx_q <= 4'd11) begin
                        hdr_src_d = {hdr_src_q[39:0], bus.fifo_data};
                    end else if (idx_q == 4'd12) begin
                        type_hi_d = bus.fifo_data;
                    end else begin
                        state_d     = PAYLOAD;
                        pcnt_d      = '0;
                        ipv4_d      = 1'b0;
                        len_known_d = 1'b1;
                        if (hdr_type == ETH_IPV4) begin
                            ipv4_d      = 1'b1;
                            len_known_d = 1'b0;
                        end else if (hdr_type == ETH_ARP) begin
                            len_d = ARP_LEN;
                        end else if (hdr_type != 16'd0 && hdr_type <= MaxLen) begin
                            len_d = hdr_type;
                        end else begin
                            drop_d      = 1'b1;
                            state_d     = HUNT;
                            len_known_d = len_known_q;
                        end
                        // Header fields become visible only for frames that are delivered.
                        if (state_d == PAYLOAD) begin
                            src_mac_d    = hdr_src_q;
                            frame_type_d = hdr_type;
                        end
                    end
                end
                PAYLOAD: begin
                    load      = 1'b1;
                    beat.data = bus.fifo_data;
                    beat.sof  = (pcnt_q == 11'd0);
                    pcnt_d    = pcnt_q + 11'd1;
                    if (ipv4_q && pcnt_q == 11'd2) begin
                        ip_hi_d = bus.fifo_data;
                    end else if (ipv4_q && pcnt_q == 11'd3) begin
                        if (ip_total < IPV4_MIN_LEN || ip_total > MaxLen) begin
                            beat.eof = 1'b1;
                            beat.err = 1'b1;
                        end else begin
                            len_d       = ip_total;
                            len_known_d = 1'b1;
                        end
                    end
                    if (len_known_q && {5'd0, pcnt_q} == len_q - 16'd1) beat.eof = 1'b1;
                    if (beat.eof) begin
                        state_d   = HUNT;
                        pre_cnt_d = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    ethernet_out_reg u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .beat_in   (beat),
        .ready     (bus.out_ready),
        .valid     (out_valid),
        .beat_out  (out_beat),
        .slot_free (slot_free)
    );

    assign bus.fifo_rd       = pop;
    assign bus.out_valid     = out_valid;
    assign bus.out_data      = out_beat.data;
    assign bus.out_sof       = out_beat.sof;
    assign bus.out_eof       = out_beat.eof;
    assign bus.out_err       = out_beat.err;
    assign bus.src_mac       = src_mac_q;
    assign bus.frame_type    = frame_type_q;
    assign bus.frame_dropped = drop_q;

endmodule

// File: tb/tb_ethernet_frame_parser.sv
// Directed bench for ethernet_frame_parser: frames are built from fields and a field-level model
// predicts every delivered beat and every drop.
module tb_ethernet_frame_parser;

    localparam logic [47:0] MY_MAC = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST  = 48'hFFFF_FFFF_FFFF;

    typedef struct packed {
        logic [7:0]  data;
        logic        sof;
        logic        eof;
        logic        err;
        logic [47:0] src;
        logic [15:0] typ;
    } exp_t;

    logic clk;
    logic reset;
    logic enable;

    ethernet_frame_parser_if bus ();

    ethernet_frame_parser #(
        .MY_MAC  (MY_MAC),
        .PRE_MIN (2),
        .MAX_LEN (1500)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t       exp_q[$];
    logic [7:0] stim_q[$];
    int         total = 0;
    int         bad = 0;
    int         exp_drops = 0;
    int         seen_drops = 0;
    int         beats_seen = 0;
    int         ready_low_cnt = 0;
    bit         toggle_empty = 0;
    bit         rd_seen = 0;
    bit         phase = 0;
    logic [47:0] last_src = '0;
    logic [15:0] last_type = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h required=%0h", name, got, want);
        end
    endtask

    // Field-level model: which beats a frame must produce, or whether it is dropped.
    task automatic model(input logic [47:0] dest, input logic [47:0] src, input logic [15:0] typ,
                         input logic [7:0] pl[$], output int n);
        int tl;
        bit err;
        err = 0;
        n   = 0;
        if (dest != MY_MAC && dest != BCAST) begin
            exp_drops++;
            n = -1;
            return;
        end
        if (typ == 16'h0800) begin
            tl = int'({pl[2], pl[3]});
            if (tl < 20 || tl > 1500) begin
                n   = 4;
                err = 1;
            end else begin
                n = tl;
            end
        end else if (typ == 16'h0806) begin
            n = 28;
        end else if (typ >= 16'd1 && typ <= 16'd1500) begin
            n = int'(typ);
        end else begin
            exp_drops++;
            n = -1;
            return;
        end
        for (int i = 0; i < n; i++)
            exp_q.push_back({pl[i], (i == 0), (i == n - 1), (err && i == n - 1), src, typ});
    endtask

    task automatic send_frame(input logic [47:0] dest, input logic [47:0] src,
                              input logic [15:0] typ, input logic [7:0] pl[$],
                              input int trailer, output int n);
        for (int i = 0; i < 7; i++) stim_q.push_back(8'h55);
        stim_q.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) stim_q.push_back(dest[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) stim_q.push_back(src[i*8 +: 8]);
        stim_q.push_back(typ[15:8]);
        stim_q.push_back(typ[7:0]);
        foreach (pl[i]) stim_q.push_back(pl[i]);
        for (int i = 0; i < trailer; i++) stim_q.push_back(8'h0F);
        model(dest, src, typ, pl, n);
    endtask

    task automatic drain(input string name);
        int c;
        c = 0;
        while ((stim_q.size() != 0 || exp_q.size() != 0 || bus.out_valid) && c < 4000) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(negedge clk);
        check({name, "_drained"}, 64'(c < 4000), 64'd1);
        check({name, "_drops"}, 64'(seen_drops), 64'(exp_drops));
    endtask

    task automatic wait_beats(input int target, input string name);
        int c;
        c = 0;
        while (beats_seen < target && c < 2000) begin
            @(negedge clk);
            c++;
        end
        check(name, 64'(beats_seen >= target), 64'd1);
    endtask

    // FIFO and consumer driver: change inputs 1 after the edge, record the pop just before the next.
    initial begin
        bus.fifo_empty = 1'b1;
        bus.fifo_data  = 8'h00;
        bus.out_ready  = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rd_seen && stim_q.size() > 0) void'(stim_q.pop_front());
            phase = ~phase;
            if (ready_low_cnt > 0) begin
                bus.out_ready = 1'b0;
                ready_low_cnt--;
            end else begin
                bus.out_ready = 1'b1;
            end
            bus.fifo_empty = (stim_q.size() == 0) || (toggle_empty && phase);
            bus.fifo_data  = (stim_q.size() > 0) ? stim_q[0] : 8'h00;
            #7;
            rd_seen = bus.fifo_rd && !reset;
        end
    end

    // Compare process: every accepted beat against the model, plus stall and disable rules.
    initial begin
        exp_t       e;
        bit         stalled_prev;
        logic [7:0] prev_data;
        stalled_prev = 0;
        prev_data    = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.frame_dropped) seen_drops++;
                if (!enable) check("rd_while_disabled", 64'(bus.fifo_rd), 64'd0);
                if (bus.out_valid && !bus.out_ready) begin
                    check("rd_during_stall", 64'(bus.fifo_rd), 64'd0);
                    if (stalled_prev) check("data_hold", 64'(bus.out_data), 64'(prev_data));
                    stalled_prev = 1;
                    prev_data    = bus.out_data;
                end else begin
                    stalled_prev = 0;
                end
                if (bus.out_valid && bus.out_ready) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_beat: got data=%0h sof=%0b eof=%0b required none",
                                 bus.out_data, bus.out_sof, bus.out_eof);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.out_data !== e.data || bus.out_sof !== e.sof ||
                            bus.out_eof !== e.eof || bus.out_err !== e.err ||
                            bus.src_mac !== e.src || bus.frame_type !== e.typ) begin
                            bad++;
                            $display("FAIL beat[%0d]: got d=%0h s=%0b e=%0b r=%0b src=%0h t=%0h required d=%0h s=%0b e=%0b r=%0b src=%0h t=%0h",
                                     beats_seen, bus.out_data, bus.out_sof, bus.out_eof,
                                     bus.out_err, bus.src_mac, bus.frame_type, e.data, e.sof,
                                     e.eof, e.err, e.src, e.typ);
                        end
                    end
                    beats_seen++;
                    last_src  = bus.src_mac;
                    last_type = bus.frame_type;
                end
            end
        end
    end

    initial begin
        logic [7:0] pl[$];
        int n;
        int base;

        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_flags", 64'({bus.out_sof, bus.out_eof, bus.out_err}), 64'd0);
        check("rst_data", 64'(bus.out_data), 64'd0);
        check("rst_src", 64'(bus.src_mac), 64'd0);
        check("rst_type", 64'(bus.frame_type), 64'd0);
        check("rst_drop", 64'(bus.frame_dropped), 64'd0);
        reset  = 1'b0;
        enable = 1'b1;

        // Basic 5-byte length frame
        pl = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        send_frame(MY_MAC, 48'h1122_3344_5566, 16'h0005, pl, 4, n);
        check("model_basic_len", 64'(n), 64'd5);
        drain("basic");
        check("basic_src", 64'(last_src), 64'h1122_3344_5566);
        check("basic_type", 64'(last_type), 64'h0005);
        check("basic_beats", 64'(beats_seen), 64'd5);

        // Foreign destination dropped, then a good frame
        send_frame(48'h02_00_00_00_00_99, 48'h1122_3344_5566, 16'h0005, pl, 4, n);
        pl = '{8'hB0, 8'hB1, 8'hB2};
        send_frame(MY_MAC, 48'hAABB_CCDD_EEFF, 16'h0003, pl, 2, n);
        drain("filter");
        check("filter_drop_cnt", 64'(seen_drops), 64'd1);
        check("filter_beats", 64'(beats_seen), 64'd8);

        // Broadcast ARP with pad and FCS, then an immediately following frame
        pl = {};
        for (int i = 0; i < 28; i++) pl.push_back(8'(8'h10 + i));
        for (int i = 0; i < 18; i++) pl.push_back(8'h00);
        send_frame(BCAST, 48'h0A0B_0C0D_0E0F, 16'h0806, pl, 4, n);
        check("model_arp_len", 64'(n), 64'd28);
        pl = '{8'hC0, 8'hC1};
        send_frame(MY_MAC, 48'h0102_0304_0506, 16'h0002, pl, 0, n);
        drain("arp");
        check("arp_next_type", 64'(last_type), 64'h0002);

        // IPv4 total length 46 with a 5-cycle consumer stall mid-payload
        pl = '{8'h45, 8'h00, 8'h00, 8'h2E};
        for (int i = 4; i < 46; i++) pl.push_back(8'(i));
        base = beats_seen;
        send_frame(MY_MAC, 48'h1111_2222_3333, 16'h0800, pl, 4, n);
        check("model_ipv4_len", 64'(n), 64'd46);
        wait_beats(base + 10, "ipv4_reach_mid");
        ready_low_cnt = 5;
        drain("ipv4");
        check("ipv4_beats", 64'(beats_seen - base), 64'd46);

        // IPv4 total length below minimum: eof+err on byte 3
        pl = '{8'h45, 8'h00, 8'h00, 8'h10};
        for (int i = 0; i < 12; i++) pl.push_back(8'h01);
        send_frame(MY_MAC, 48'h1111_2222_3333, 16'h0800, pl, 4, n);
        check("model_ipv4_short", 64'(n), 64'd4);
        drain("ipv4_short");

        // Type boundaries: 1501 and 0 dropped, 1 is a single sof+eof byte
        pl = '{8'h0F, 8'h0F};
        send_frame(MY_MAC, 48'h0, 16'd1501, pl, 0, n);
        send_frame(BCAST, 48'h0, 16'd0, pl, 0, n);
        pl = '{8'h7E, 8'h00, 8'h00};
        send_frame(MY_MAC, 48'hFEDC_BA98_7654, 16'd1, pl, 0, n);
        drain("types");
        check("types_drop_cnt", 64'(seen_drops), 64'd3);
        check("type1_src", 64'(last_src), 64'hFEDC_BA98_7654);

        // Gappy FIFO plus an enable-low window
        toggle_empty = 1;
        pl = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        send_frame(MY_MAC, 48'h1122_3344_5566, 16'h0005, pl, 4, n);
        repeat (12) @(negedge clk);
        enable = 1'b0;
        repeat (8) @(negedge clk);
        enable = 1'b1;
        drain("gappy");
        toggle_empty = 0;

        // Asynchronous reset mid-payload, then a fresh frame
        pl = {};
        for (int i = 0; i < 40; i++) pl.push_back(8'(8'h60 + i));
        base = beats_seen;
        send_frame(MY_MAC, 48'h0102_0304_0506, 16'd40, pl, 0, n);
        wait_beats(base + 10, "reset_reach_mid");
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_valid", 64'(bus.out_valid), 64'd0);
        stim_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        pl = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
        base = beats_seen;
        send_frame(MY_MAC, 48'h0606_0505_0404, 16'd4, pl, 2, n);
        drain("after_reset");
        check("after_reset_beats", 64'(beats_seen - base), 64'd4);
        check("after_reset_src", 64'(last_src), 64'h0606_0505_0404);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ethernet_frame_parser.md
Name: ethernet_frame_parser

Overview:
- Consumes the byte stream from the receive FIFO that follows the frame aggregator: fifo_empty, fifo_data and fifo_rd.
- Hunts for preamble/SFD, captures the 14-byte MAC header and filters on destination address.
- Delivers payload bytes with start/end markers to the protocol layer under a valid/ready handshake.
- Trailing pad/FCS bytes are discarded by returning to hunt.

Parameters:
- MY_MAC, 48'h02_00_00_00_00_01: station address accepted besides broadcast.
- PRE_MIN, 2: minimum consecutive 0x55 bytes before 0xD5 counts as SFD.
- MAX_LEN, 1500: largest accepted payload length.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  PHY initialised (driven from ethernet_ready); parser idles while low
- fifo_empty  in  1  FIFO empty flag
- fifo_data  in  8  FIFO head byte (first-word-fall-through; valid when !fifo_empty)
- fifo_rd  out  1  pop strobe, combinational
- out_data  out  8  payload byte
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts byte
- out_sof  out  1  first payload byte of frame
- out_eof  out  1  last payload byte of frame
- out_err  out  1  with out_eof: frame truncated/malformed
- src_mac  out  48  source address of current frame; stable from first payload byte to eof
- frame_type  out  16  type/length field; same stability as src_mac
- frame_dropped  out  1  one-cycle pulse per filtered or rejected frame

Behaviour:
- Reset: out_valid, out_sof, out_eof, out_err and frame_dropped are 0; out_data, src_mac and frame_type are 0; state HUNT; counters 0.
- Pop rule: fifo_rd = enable && !fifo_empty && (!out_valid || out_ready). Every popped byte is processed in the same cycle. Output registers load on the following edge, giving 1-cycle latency.
- Output handshake: out_valid, out_data and the sof/eof/err flags hold until out_valid && out_ready. out_valid clears on acceptance if no new byte is loaded.
- HUNT:
  - pre_cnt counts consecutive 0x55 bytes, saturating at 7.
  - 0xD5 with pre_cnt >= PRE_MIN -> HEADER, idx = 0.
  - Any other byte clears pre_cnt.
- HEADER (idx 0..13):
  - Bytes 0-5 form the destination address (byte 0 = MSB). After byte 5, if dest != MY_MAC and dest != 48'hFFFF_FFFF_FFFF: pulse frame_dropped, go to HUNT.
  - Bytes 6-11 form src_mac; bytes 12-13 form frame_type (12 = MSB).
  - At byte 13, decide the length:
    - type 1..MAX_LEN: len = type.
    - 0x0806: len = 28.
    - 0x0800: len unknown (IPv4 mode).
    - Type 0, MAX_LEN < type < 0x0600, or any other type: frame_dropped, go to HUNT.
  - Accepted frames go to PAYLOAD with pcnt = 0.
- PAYLOAD:
  - Each popped byte is emitted; out_sof is set when pcnt == 0; pcnt increments (11 bits).
  - IPv4 mode: len = {byte2, byte3} (IP total length), latched when byte 3 is popped.
  - If the latched total length < 20, byte 3 carries out_eof = 1 and out_err = 1.
  - out_eof is set on the byte where pcnt == len-1; then go to HUNT.
  - Length known and > MAX_LEN: emit out_eof and out_err on the current byte, go to HUNT.
- enable low: fifo_rd = 0. The state and the output register are held, and a pending output still completes its handshake.
- Asynchronous reset mid-frame: everything returns to reset values at once. A partially delivered frame is abandoned without eof, and the consumer must treat reset as abort.
- Bytes after eof (padding, FCS, inter-frame garbage) are consumed in HUNT.

Decomposition:
- Shared package ethernet_pkg holds:
  - Byte constants: PREAMBLE 8'h55, SFD 8'hD5.
  - Ethertypes: ETH_IPV4 16'h0800, ETH_ARP 16'h0806.
  - BROADCAST_MAC, ARP_LEN 28, IPV4_MIN_LEN 20.
  - State enumeration HUNT/HEADER/PAYLOAD.
- One natural sub-module, ethernet_out_reg: the 1-entry output register with the valid/ready hold logic, which produces the "slot free" term used in the pop rule.

Test Plan:
- Preamble 0x55×7, 0xD5, dest MY_MAC, src 11:22:33:44:55:66, type 0x0005, payload A0..A4 -> five bytes out; sof on A0; eof on A4; src_mac = 0x112233445566; frame_type = 0x0005; no drop.
- Same frame with dest 02:00:00:00:00:99 -> frame_dropped pulses once after dest byte 5; no out_valid; a following valid frame is parsed normally.
- ARP frame (type 0x0806) to broadcast with 28 payload bytes plus 18 pad bytes and 4 FCS bytes, then the next frame -> exactly 28 bytes out with eof on byte 27; pad/FCS ignored; the next frame's sof is correct.
- IPv4 frame with total length 0x002E (46) -> 46 bytes out, eof on byte 45. Total length 0x0010 -> eof and err both on byte 3.
- out_ready held low 5 cycles mid-payload -> fifo_rd stays 0 and out_data is stable; resuming loses and duplicates no byte. fifo_empty toggling every cycle gives the same byte sequence.
- Assert reset mid-payload -> out_valid drops to 0 immediately (asynchronously). A frame sent after release parses correctly starting from HUNT.
